// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction fetch stage sitting directly in front of a combinational
//   instruction ROM. Holds the program counter, presents it to the ROM as the
//   fetch address, captures the returned word with its PC into a small FIFO,
//   and hands the FIFO head to decode over a valid/ready handshake. A redirect
//   from execute flushes the FIFO and reloads the PC.
//
// Parameters
//   RESET_PC  PC loaded on reset (bits [1:0] expected to be zero)
//   DEPTH     FIFO entries, power of two, >= 2
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   fetch_en     1 = fetch allowed this cycle, 0 = hold PC and push nothing
//   pc_addr      fetch address to the ROM (the PC register)
//   rom_inst     ROM word for pc_addr, valid in the same cycle
//   redirect     one-cycle pulse: flush FIFO, next PC = redirect_pc
//   redirect_pc  redirect target, bits [1:0] forced to zero
//   if_valid     FIFO head holds a valid instruction
//   if_ready     decode accepts the head this cycle
//   if_inst      head instruction word (0 while empty)
//   if_pc        PC of the head instruction (0 while empty)
//   if_pc_plus4  if_pc + 4 modulo 2^32 (0 while empty)
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] pc_addr,
    input  logic [31:0] rom_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];
    logic          pop;
    logic          push;
    logic [31:0]   head_pc;

    // The two lowest target bits are never used: targets are word aligned.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pc_addr  = pc;
    assign if_valid = (count != '0);

    // A push is allowed into a full FIFO when the head leaves in the same
    // cycle, which keeps a full pipe streaming at one instruction per cycle.
    assign pop  = if_valid & if_ready;
    assign push = fetch_en & ~redirect & ((count < DEPTH_CNT) | pop);

    // Head outputs are combinational from the storage so a captured word is
    // visible the cycle after its fetch; zeros are shown while empty.
    assign head_pc     = pc_mem[rd_ptr];
    assign if_inst     = if_valid ? inst_mem[rd_ptr] : 32'h0;
    assign if_pc       = if_valid ? head_pc : 32'h0;
    assign if_pc_plus4 = if_valid ? head_pc + 32'd4 : 32'h0;

    // FIFO storage needs no reset: its contents are only observed through
    // count, which reset clears.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= rom_inst;
            pc_mem[wr_ptr]   <= pc;
        end
    end

    // PC, pointers and occupancy. Redirect overrides push and pop; a pop in
    // the redirect cycle still completes for decode but the entry is dropped
    // along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed bench for inst_fetch_unit. A behavioural ROM feeds two instances:
//   one with the default reset PC for the main sequence and one with a reset
//   PC near the top of the address space for the wrap case. Expected head
//   entries are queued when a fetch is accepted and compared as they reach
//   the head.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        if_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        fetch_en2;
    logic        if_ready2;
    logic [31:0] pc_addr2;
    logic [31:0] rom_inst2;
    logic        if_valid2;
    logic [31:0] if_inst2;
    logic [31:0] if_pc2;
    logic [31:0] if_pc_plus4_2;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb[$];
    logic [31:0] mpc;

    // ROM contents: a scrambled function of the address, with one all-zero
    // word at 0x10 to show zero words are fetched like any other.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h10) return 32'h0;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rom_inst  = rom(pc_addr);
    assign rom_inst2 = rom(pc_addr2);

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_addr(pc_addr),
        .rom_inst(rom_inst), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en2), .pc_addr(pc_addr2),
        .rom_inst(rom_inst2), .redirect(1'b0), .redirect_pc(32'h0),
        .if_valid(if_valid2), .if_ready(if_ready2), .if_inst(if_inst2),
        .if_pc(if_pc2), .if_pc_plus4(if_pc_plus4_2)
    );

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare the DUT head and fetch address with the expected state.
    task automatic checkOutput();
        logic [63:0] head;
        cmp("pc_addr", pc_addr, mpc);
        if (sb.size() > 0) begin
            head = sb[0];
            cmp("if_valid", {31'b0, if_valid}, 32'd1);
            cmp("if_inst", if_inst, head[63:32]);
            cmp("if_pc", if_pc, head[31:0]);
            cmp("if_pc_plus4", if_pc_plus4, head[31:0] + 32'd4);
        end else begin
            cmp("if_valid", {31'b0, if_valid}, 32'd0);
            cmp("if_inst_empty", if_inst, 32'h0);
            cmp("if_pc_empty", if_pc, 32'h0);
            cmp("if_pc_plus4_empty", if_pc_plus4, 32'h0);
        end
    endtask

    // Drive one cycle of inputs, check the current outputs, then advance the
    // expected state across the clock edge.
    task automatic applyStimulus(input logic fe, input logic rdy,
                                 input logic rd, input logic [31:0] rpc);
        logic        mpop;
        logic        mpush;
        logic [31:0] word;
        fetch_en    = fe;
        if_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        checkOutput();
        mpop  = (sb.size() > 0) && rdy;
        mpush = fe && !rd && ((sb.size() < 2) || mpop);
        word  = rom(mpc);
        @(posedge clk);
        if (rd) begin
            sb.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            if (mpop) void'(sb.pop_front());
            if (mpush) begin
                sb.push_back({word, mpc});
                mpc = mpc + 32'd4;
            end
        end
        #1;
    endtask

    // Bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int          hs;
        logic [31:0] start_pc;

        rst_n       = 1'b1;
        fetch_en    = 1'b0;
        if_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fetch_en2   = 1'b0;
        if_ready2   = 1'b0;
        mpc         = 32'h0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput();
        cmp("hi_reset_pc", pc_addr2, 32'hFFFF_FFF8);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] sequential fetch with decode always ready");
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] decode stall fills the FIFO and holds the PC");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        cmp("stall_pc_addr", pc_addr, 32'h8);
        cmp("stall_inst", if_inst, rom(32'h0));
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        $display("[TB] redirect while full");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0037);
        cmp("redir_valid", {31'b0, if_valid}, 32'd0);
        cmp("redir_pc_addr", pc_addr, 32'h34);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        cmp("redir_if_pc", if_pc, 32'h34);

        $display("[TB] full FIFO streaming");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        hs       = 0;
        start_pc = pc_addr;
        for (int i = 0; i < 6; i++) begin
            if (if_valid) hs++;
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        end
        cmp("stream_handshakes", 32'(hs), 32'd6);
        cmp("stream_pc_advance", pc_addr, start_pc + 32'd24);

        $display("[TB] asynchronous reset with entries buffered");
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        cmp("pre_reset_valid", {31'b0, if_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_valid", {31'b0, if_valid}, 32'd0);
        cmp("async_pc_addr", pc_addr, 32'h0);
        sb.delete();
        mpc      = 32'h0;
        fetch_en = 1'b0;
        if_ready = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();

        $display("[TB] PC wrap from top of address space");
        fetch_en2 = 1'b1;
        if_ready2 = 1'b1;
        #1;
        cmp("wrap_pc0", pc_addr2, 32'hFFFF_FFF8);
        cmp("wrap_valid0", {31'b0, if_valid2}, 32'd0);
        @(posedge clk);
        #1;
        cmp("wrap_pc1", pc_addr2, 32'hFFFF_FFFC);
        cmp("wrap_if_pc1", if_pc2, 32'hFFFF_FFF8);
        cmp("wrap_inst1", if_inst2, rom(32'hFFFF_FFF8));
        @(posedge clk);
        #1;
        cmp("wrap_pc2", pc_addr2, 32'h0);
        cmp("wrap_if_pc2", if_pc2, 32'hFFFF_FFFC);
        cmp("wrap_plus4_2", if_pc_plus4_2, 32'h0);
        @(posedge clk);
        #1;
        cmp("wrap_if_pc3", if_pc2, 32'h0);
        cmp("wrap_plus4_3", if_pc_plus4_2, 32'h4);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
